// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD constants, FSM encodings and elaboration helpers.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } bcd_state_t;

    // Number of bits needed to represent 'value'.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Decimal digits required to hold the largest value of 'width' bits.
    function automatic int bcd_digits(input int width);
        longint unsigned v;
        int d;
        v = (64'd1 << width) - 64'd1;
        d = 0;
        do begin
            d = d + 1;
            v = v / 64'd10;
        end while (v != 64'd0);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd
// Brief    : Sequential double-dabble converter with saturating BCD output.
// Revision : 1.0
// ============================================================================
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [BIN_WIDTH-1:0]                i_bin,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_overflow,
    output logic [DISPLAYS_NUM*BCD_DIGIT_W-1:0] o_bcd_data
);

    localparam int c_NEED_DIG = bcd_digits(BIN_WIDTH);
    localparam int c_DIG      = (c_NEED_DIG > DISPLAYS_NUM) ? c_NEED_DIG : DISPLAYS_NUM;
    localparam int c_DW       = c_DIG * BCD_DIGIT_W;
    localparam int c_SW       = c_DW + BIN_WIDTH;
    localparam int c_OW       = DISPLAYS_NUM * BCD_DIGIT_W;
    localparam int c_CW       = clogb2(BIN_WIDTH + 1);

    localparam logic [c_CW-1:0]      c_LAST    = c_CW'(BIN_WIDTH - 1);
    localparam longint unsigned      c_MAX_VAL = pow10(DISPLAYS_NUM) - 64'd1;
    localparam logic [c_OW-1:0]      c_SAT     = {DISPLAYS_NUM{4'h9}};

    bcd_state_t        r_state;
    bcd_state_t        w_next_state;
    logic              w_accept;
    logic              w_last_step;
    logic              w_in_over;
    logic [c_SW-1:0]   r_shift;
    logic [c_SW-1:0]   w_step;
    logic [c_DW-1:0]   w_adj;
    logic [c_CW-1:0]   r_cnt;
    logic              r_ovf_pend;
    logic              r_overflow;
    logic [c_OW-1:0]   r_bcd;

    // Saturation is decided on the full operand, before any digit is dropped.
    assign w_in_over   = (64'(i_bin) > c_MAX_VAL);
    assign w_last_step = (r_cnt == c_LAST);

    for (genvar g = 0; g < c_DIG; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (r_shift[BIN_WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_step = {w_adj, r_shift[BIN_WIDTH-1:0]} << 1;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_last_step) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_CONV;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_bcd      <= '0;
        end else if (w_accept) begin
            r_shift    <= {{c_DW{1'b0}}, i_bin};
            r_cnt      <= '0;
            r_ovf_pend <= w_in_over;
        end else if (r_state == ST_CONV) begin
            r_shift <= w_step;
            r_cnt   <= r_cnt + 1'b1;
            // Publish on the final step so the display only sees whole results.
            if (w_last_step) begin
                r_bcd      <= r_ovf_pend ? c_SAT : w_step[BIN_WIDTH +: c_OW];
                r_overflow <= r_ovf_pend;
            end
        end
    end

    assign o_busy     = (r_state == ST_CONV);
    assign o_done     = (r_state == ST_DONE);
    assign o_overflow = r_overflow;
    assign o_bcd_data = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd
// Brief    : Scoreboard bench for bin_to_bcd (4 digits / 14 bits and 2 digits / 7 bits).
// Revision : 1.0
// ============================================================================
module tb_bin_to_bcd;

    logic        clk;
    logic        rst_n;

    logic        a_start;
    logic [13:0] a_bin;
    logic        a_busy;
    logic        a_done;
    logic        a_ovf;
    logic [15:0] a_bcd;

    logic        b_start;
    logic [6:0]  b_bin;
    logic        b_busy;
    logic        b_done;
    logic        b_ovf;
    logic [7:0]  b_bcd;

    logic [16:0] qa[$];
    logic [8:0]  qb[$];

    int n_cmp;
    int n_bad;

    bin_to_bcd #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) u_dut_a (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_start    (a_start),
        .i_bin      (a_bin),
        .o_busy     (a_busy),
        .o_done     (a_done),
        .o_overflow (a_ovf),
        .o_bcd_data (a_bcd)
    );

    bin_to_bcd #(.DISPLAYS_NUM(2), .BIN_WIDTH(7)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_start    (b_start),
        .i_bin      (b_bin),
        .o_busy     (b_busy),
        .o_done     (b_done),
        .o_overflow (b_ovf),
        .o_bcd_data (b_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL A unexpected done: got bcd %0h expected no result", a_bcd);
            end else begin
                logic [16:0] e;
                e = qa.pop_front();
                check("A bcd", 32'(a_bcd), 32'(e[15:0]));
                check("A ovf", 32'(a_ovf), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (b_done === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL B unexpected done: got bcd %0h expected no result", b_bcd);
            end else begin
                logic [8:0] e;
                e = qb.pop_front();
                check("B bcd", 32'(b_bcd), 32'(e[7:0]));
                check("B ovf", 32'(b_ovf), 32'(e[8]));
            end
        end
    end

    task automatic wait_a(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (a_done !== 1'b1 && n < 200);
        if (a_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL A timeout: got no done expected done within 200 cycles");
        end
    endtask

    // Single-pulse conversion on A; returns edges from acceptance to done and busy cycles.
    task automatic a_run(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                         output int edges, output int busy_n);
        qa.push_back({eo, eb});
        a_bin   = v;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        edges   = 1;
        busy_n  = 0;
        while (a_done !== 1'b1 && edges < 200) begin
            if (a_busy === 1'b1) busy_n++;
            @(posedge clk);
            edges++;
            #1;
        end
        if (a_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL A run timeout: got no done expected done for %0d", v);
        end
    endtask

    task automatic b_run(input logic [6:0] v, input logic [7:0] eb, input logic eo, output int edges);
        qb.push_back({eo, eb});
        b_bin   = v;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        edges   = 1;
        while (b_done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
        if (b_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL B run timeout: got no done expected done for %0d", v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1000000");
        $fatal(1, "watchdog expired");
    end

    logic [13:0] bnd_in  [4] = '{14'd0, 14'd9999, 14'd10000, 14'd16383};
    logic [15:0] bnd_bcd [4] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
    logic        bnd_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int edges;
        int busy_n;
        int n;
        int pulses;
        logic [7:0] eb;

        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a_start = 1'b1;
        a_bin   = 14'd1234;
        b_start = 1'b0;
        b_bin   = '0;

        // Reset state, start held high during reset must be ignored
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(a_busy), 32'd0);
        check("reset done", 32'(a_done), 32'd0);
        check("reset ovf",  32'(a_ovf),  32'd0);
        check("reset bcd",  32'(a_bcd),  32'd0);
        a_start = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("idle after reset busy", 32'(a_busy), 32'd0);

        // 1234: latency and busy duration
        a_run(14'd1234, 16'h1234, 1'b0, edges, busy_n);
        check("1234 latency", 32'(edges), 32'd15);
        check("1234 busy cycles", 32'(busy_n), 32'd14);
        @(posedge clk);
        #1;
        check("done single pulse", 32'(a_done), 32'd0);
        check("idle after done", 32'(a_busy), 32'd0);
        check("result held", 32'(a_bcd), 32'h1234);

        // Boundaries, ending with a saturated result
        for (int i = 0; i < 4; i++) begin
            a_run(bnd_in[i], bnd_bcd[i], bnd_ovf[i], edges, busy_n);
        end

        // Reset mid-conversion of 4321: outputs clear immediately, no done
        a_bin   = 14'd4321;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n   = 1'b0;
        a_start = 1'b1;
        #1;
        check("async reset busy", 32'(a_busy), 32'd0);
        check("async reset done", 32'(a_done), 32'd0);
        check("async reset ovf",  32'(a_ovf),  32'd0);
        check("async reset bcd",  32'(a_bcd),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        a_start = 1'b0;
        rst_n   = 1'b1;
        pulses  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (a_done === 1'b1) pulses++;
        end
        check("no done after reset", 32'(pulses), 32'd0);
        a_run(14'd4321, 16'h4321, 1'b0, edges, busy_n);

        // Back-to-back: start held high, 42 then 7
        qa.push_back({1'b0, 16'h0042});
        qa.push_back({1'b0, 16'h0007});
        a_bin   = 14'd42;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_bin = 14'd7;
        wait_a(n);
        check("b2b first latency", 32'(n + 1), 32'd15);
        wait_a(n);
        check("b2b done period", 32'(n), 32'd15);
        a_start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b idle", 32'(a_busy), 32'd0);
        check("b2b done low", 32'(a_done), 32'd0);

        // Start mid-conversion is ignored
        qa.push_back({1'b0, 16'h5678});
        a_bin   = 14'd5678;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        pulses  = 0;
        repeat (3) @(posedge clk);
        #1;
        a_bin   = 14'd1111;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_bin   = 14'd0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (a_done === 1'b1) pulses++;
        end
        check("mid-conv done pulses", 32'(pulses), 32'd1);
        check("mid-conv held", 32'(a_bcd), 32'h5678);

        // Narrow instance: full sweep
        for (int v = 0; v < 128; v++) begin
            if (v < 100) eb = {4'(v / 10), 4'(v % 10)};
            else         eb = 8'h99;
            b_run(7'(v), eb, (v > 99), edges);
            if (v == 0) check("B latency", 32'(edges), 32'd8);
        end

        repeat (4) @(posedge clk);
        #1;
        check("A queue drained", 32'(qa.size()), 32'd0);
        check("B queue drained", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
